bias_act_stage: RTL and testbench
=================================

Name: bias_act_stage

Overview:
- Sequential post-processing stage directly downstream of the vector-matrix product block.
- Consumes the NUM_COL_MAT-element fixed-point product vector when the product block's done fires.
- Adds a per-neuron bias with saturation, applies an optional ReLU, and tracks the argmax index.
- Presents the registered layer output to the next layer or the classifier, one element processed per cycle.

Parameters:
- FRACTION_WIDTH, 15, fractional bits of the signed two's-complement fixed-point format; informational only, since the bias add needs no rescale.
- BIT_WIDTH, 32, width of every data element.
- NUM_COL_MAT, 5, number of elements in the vector (neurons in the layer); must be at least 1.
- ACT_MODE, 1, activation select: 0 = identity, 1 = ReLU.
- IDX_WIDTH, $clog2(NUM_COL_MAT) with a minimum of 1, width of argmax_idx.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  capture request; driven by the upstream product block's done.
- vec_in  in  BIT_WIDTH x [NUM_COL_MAT-1:0]  product vector (signed).
- bias  in  BIT_WIDTH x [NUM_COL_MAT-1:0]  bias vector (signed, same Q format).
- result  out  BIT_WIDTH x [NUM_COL_MAT-1:0]  activated layer output, registered.
- argmax_idx  out  IDX_WIDTH  index of the largest post-activation element.
- busy  out  1  high while the stage is in RUN or DONE.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- While rst is asserted:
  - state = IDLE, element counter = 0, internal buffers = 0.
  - result all 0, argmax_idx = 0, busy = 0, done = 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - If start = 1 at rising edge t, latch all of vec_in and bias into internal registers, set k = 0, go to RUN.
  - vec_in and bias are not sampled again after edge t, so upstream may change them freely afterwards.
- RUN (element k is processed at edge t+1+k):
  - sum = sign-extend(vec[k]) + sign-extend(bias[k]), computed at BIT_WIDTH+1 bits.
  - Saturate sum to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1]; with the defaults that is 0x80000000 to 0x7FFFFFFF.
  - ACT_MODE = 1: a negative saturated value becomes 0. ACT_MODE = 0: pass the value through.
  - Write the value into shadow buffer slot k.
  - Argmax update:
    - k = 0 loads best value and best index (0).
    - For k > 0, replace only if the value is strictly greater than the current best; ties keep the lower index.
    - The comparison is signed.
  - At edge t+NUM_COL_MAT (k = NUM_COL_MAT-1 processed), copy the shadow buffer to result and the best index to argmax_idx, then go to DONE.
- DONE: done = 1 for exactly this one cycle, then go to IDLE at the next edge.
- Latency: done is high in the cycle after edge t+NUM_COL_MAT, i.e. NUM_COL_MAT+1 cycles after start is sampled.
- Throughput: a new start is accepted from the cycle after the done pulse at the earliest.
- busy = 1 in RUN and DONE; 0 in IDLE.
- result and argmax_idx change only on the transition into DONE and hold until the next completion. Partial results are never visible.
- start while in RUN or DONE is ignored: no queuing, no restart, no error flag.
- start held high continuously: re-captured on the first IDLE cycle after DONE, so back-to-back operations have a period of NUM_COL_MAT+2 cycles.
- rst asserted mid-RUN:
  - Aborts the operation immediately and clears the outputs to 0.
  - No done pulse for the aborted operation.
  - A start after rst deasserts runs normally.
- NUM_COL_MAT = 1: RUN lasts one cycle, argmax_idx = 0.

Test Plan:
- Basic, ACT_MODE = 1, NUM_COL_MAT = 5, Q15:
  - Stimulus: vec = {0x8000, 0xFFFF0000, 0x4000, 0x18000, 0}, bias = {0x8000, 0, 0x4000, 0, 0xFFFFC000}, start pulse.
  - Required: result = {0x10000, 0, 0x8000, 0x18000, 0}, argmax_idx = 3; done high exactly 6 cycles after start; busy high for 6 cycles.
- Saturation, ACT_MODE = 0:
  - Stimulus: vec[0] = 0x7FFFFF00, bias[0] = 0x1000; vec[1] = 0x80000100, bias[1] = 0xFFFFF000.
  - Required: result[0] = 0x7FFFFFFF, result[1] = 0x80000000.
- Argmax ties and negatives, ACT_MODE = 0:
  - Stimulus: all values -0x8000 except elements 2 and 4, both 0x8000.
  - Required: argmax_idx = 2. Repeat with all elements equal and negative -> argmax_idx = 0.
- Start during busy:
  - Stimulus: start, then a second start with different vec_in 2 cycles later.
  - Required: only one done pulse; result reflects the first vec_in; the next start accepted after done completes normally.
- Reset mid-run:
  - Stimulus: start, assert rst at cycle 3 for 1 cycle.
  - Required: result, argmax_idx, busy and done all 0 immediately; no done pulse. A new start then completes in 6 cycles with correct data.
- Hold:
  - Stimulus: after completion, change vec_in and bias with start = 0 for 20 cycles.
  - Required: result and argmax_idx unchanged, done stays 0.

Source files
------------

// File: rtl/bias_act_stage.sv
// Post-product stage: per-neuron bias add with saturation, optional ReLU, and argmax,
// processing one element per cycle and publishing the whole layer output at once.
//
// state | meaning
// IDLE  | waiting for start; vec_in/bias captured on start
// RUN   | element k processed each cycle into the shadow buffer
// DONE  | result/argmax_idx just updated; done pulses for this cycle
module bias_act_stage #(
    parameter int FRACTION_WIDTH = 15,
    parameter int BIT_WIDTH      = 32,
    parameter int NUM_COL_MAT    = 5,
    parameter int ACT_MODE       = 1,
    parameter int IDX_WIDTH      = (NUM_COL_MAT > 1) ? $clog2(NUM_COL_MAT) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [NUM_COL_MAT-1:0][BIT_WIDTH-1:0] vec_in,
    input  logic [NUM_COL_MAT-1:0][BIT_WIDTH-1:0] bias,
    output logic [NUM_COL_MAT-1:0][BIT_WIDTH-1:0] result,
    output logic [IDX_WIDTH-1:0]                  argmax_idx,
    output logic                                  busy,
    output logic                                  done
);

    // Bias and product share the same Q format, so the fraction width never enters the math.
    if (NUM_COL_MAT < 1 || FRACTION_WIDTH < 0 || FRACTION_WIDTH >= BIT_WIDTH) begin : g_bad_cfg
        $error("bias_act_stage: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic signed [BIT_WIDTH-1:0] SAT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [BIT_WIDTH-1:0] SAT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0]        LAST_K  = IDX_WIDTH'(NUM_COL_MAT - 1);

    state_t                       state, state_nxt;
    logic [IDX_WIDTH-1:0]         k;
    logic signed [BIT_WIDTH-1:0]  vec_r    [NUM_COL_MAT];
    logic signed [BIT_WIDTH-1:0]  bias_r   [NUM_COL_MAT];
    logic signed [BIT_WIDTH-1:0]  shadow   [NUM_COL_MAT];
    logic signed [BIT_WIDTH-1:0]  best_val;
    logic [IDX_WIDTH-1:0]         best_idx;

    logic signed [BIT_WIDTH:0]    sum;
    logic signed [BIT_WIDTH-1:0]  sat_val;
    logic signed [BIT_WIDTH-1:0]  act_val;
    logic                         last_k;
    logic                         take;

    always_comb begin
        sum     = {vec_r[k][BIT_WIDTH-1], vec_r[k]} + {bias_r[k][BIT_WIDTH-1], bias_r[k]};
        sat_val = sum[BIT_WIDTH-1:0];
        // Top two bits disagree only when the add left the BIT_WIDTH range.
        if (sum[BIT_WIDTH] != sum[BIT_WIDTH-1]) begin
            sat_val = sum[BIT_WIDTH] ? SAT_MIN : SAT_MAX;
        end
        act_val = sat_val;
        if (ACT_MODE == 1 && sat_val[BIT_WIDTH-1]) begin
            act_val = '0;
        end
        last_k = (k == LAST_K);
        take   = (k == '0) || (act_val > best_val);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_k) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k          <= '0;
            best_val   <= '0;
            best_idx   <= '0;
            result     <= '0;
            argmax_idx <= '0;
            for (int i = 0; i < NUM_COL_MAT; i++) begin
                vec_r[i]  <= '0;
                bias_r[i] <= '0;
                shadow[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k <= '0;
                        for (int i = 0; i < NUM_COL_MAT; i++) begin
                            vec_r[i]  <= vec_in[i];
                            bias_r[i] <= bias[i];
                        end
                    end
                end
                RUN: begin
                    shadow[k] <= act_val;
                    if (take) begin
                        best_val <= act_val;
                        best_idx <= k;
                    end
                    k <= last_k ? '0 : k + 1'b1;
                    // Final slot is not in the shadow buffer yet, so splice it in on the publish.
                    if (last_k) begin
                        for (int i = 0; i < NUM_COL_MAT; i++) begin
                            result[i] <= (IDX_WIDTH'(i) == k) ? act_val : shadow[i];
                        end
                        argmax_idx <= take ? k : best_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bias_act_stage.sv
// Directed bench for bias_act_stage: one ReLU and one identity instance share stimulus,
// expected values are hand-computed constants.
module tb_bias_act_stage;

    localparam int W = 32;
    localparam int N = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [N-1:0][W-1:0] vec_in;
    logic [N-1:0][W-1:0] bias;
    logic [N-1:0][W-1:0] res_relu, res_lin;
    logic [2:0]          idx_relu, idx_lin;
    logic                busy_relu, busy_lin, done_relu, done_lin;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bias_act_stage #(.FRACTION_WIDTH(15), .BIT_WIDTH(W), .NUM_COL_MAT(N), .ACT_MODE(1)) u_relu (
        .clk(clk), .rst(rst), .start(start), .vec_in(vec_in), .bias(bias),
        .result(res_relu), .argmax_idx(idx_relu), .busy(busy_relu), .done(done_relu)
    );

    bias_act_stage #(.FRACTION_WIDTH(15), .BIT_WIDTH(W), .NUM_COL_MAT(N), .ACT_MODE(0)) u_lin (
        .clk(clk), .rst(rst), .start(start), .vec_in(vec_in), .bias(bias),
        .result(res_lin), .argmax_idx(idx_lin), .busy(busy_lin), .done(done_lin)
    );

    function automatic logic [N-1:0][W-1:0] v5(input logic [W-1:0] e0, e1, e2, e3, e4);
        logic [N-1:0][W-1:0] r;
        r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3; r[4] = e4;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [N-1:0][W-1:0] obs,
                             input logic [N-1:0][W-1:0] exp);
        for (int i = 0; i < N; i++) check($sformatf("%s[%0d]", tag, i), obs[i], exp[i]);
    endtask

    // Start pulse, bounded wait for done, then one more edge back to IDLE.
    task automatic do_op(input string tag, input logic [N-1:0][W-1:0] v, input logic [N-1:0][W-1:0] b);
        logic [N-1:0][W-1:0] prev;
        int lat, bcnt, part;
        prev = res_relu;
        lat = 0; bcnt = 0; part = 0;
        vec_in = v;
        bias   = b;
        start  = 1'b1;
        do begin
            tick();
            start = 1'b0;
            lat++;
            if (busy_relu) bcnt++;
            if (!done_relu && res_relu !== prev) part++;
        end while (!done_relu && lat < 20);
        check({tag, ".latency"}, 32'(lat), 32'd6);
        check({tag, ".busy_cycles"}, 32'(bcnt), 32'd6);
        check({tag, ".partial_visible"}, 32'(part), 32'd0);
        tick();
        check({tag, ".done_after"}, 32'(done_relu), 32'd0);
        check({tag, ".busy_after"}, 32'(busy_relu), 32'd0);
    endtask

    localparam logic [W-1:0] NEG8 = 32'hFFFF8000;

    initial begin
        logic [N-1:0][W-1:0] va, vb, vbasic, bbasic, saved;
        logic [2:0] saved_idx;
        int dcnt, chg, per, w;

        vbasic = v5(32'h8000, 32'hFFFF0000, 32'h4000, 32'h18000, 32'h0);
        bbasic = v5(32'h8000, 32'h0, 32'h4000, 32'h0, 32'hFFFFC000);
        va     = v5(32'h1000, 32'h5000, 32'h2000, 32'h3000, 32'h4000);
        vb     = v5(32'h0, 32'h100, 32'h200, 32'h9000, 32'h300);

        rst = 1'b1; start = 1'b0; vec_in = '0; bias = '0;
        #12;
        check_vec("reset.result", res_relu, '0);
        check("reset.argmax", 32'(idx_relu), 32'd0);
        check("reset.busy", 32'(busy_relu), 32'd0);
        check("reset.done", 32'(done_relu), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        do_op("basic", vbasic, bbasic);
        check_vec("basic.relu", res_relu, v5(32'h10000, 32'h0, 32'h8000, 32'h18000, 32'h0));
        check("basic.relu_idx", 32'(idx_relu), 32'd3);
        check_vec("basic.lin", res_lin, v5(32'h10000, 32'hFFFF0000, 32'h8000, 32'h18000, 32'hFFFFC000));
        check("basic.lin_idx", 32'(idx_lin), 32'd3);

        do_op("sat", v5(32'h7FFFFF00, 32'h80000100, 32'h7FFFFFFE, 32'h0, 32'h0),
                     v5(32'h1000, 32'hFFFFF000, 32'h1, 32'h0, 32'h0));
        check_vec("sat.lin", res_lin, v5(32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0));
        check("sat.lin_idx", 32'(idx_lin), 32'd0);
        check_vec("sat.relu", res_relu, v5(32'h7FFFFFFF, 32'h0, 32'h7FFFFFFF, 32'h0, 32'h0));

        do_op("tie", v5(NEG8, NEG8, 32'h8000, NEG8, 32'h8000), '0);
        check("tie.lin_idx", 32'(idx_lin), 32'd2);
        check("tie.relu_idx", 32'(idx_relu), 32'd2);
        check_vec("tie.relu", res_relu, v5(32'h0, 32'h0, 32'h8000, 32'h0, 32'h8000));

        do_op("alleq", v5(NEG8, NEG8, NEG8, NEG8, NEG8), '0);
        check("alleq.lin_idx", 32'(idx_lin), 32'd0);
        check_vec("alleq.lin", res_lin, v5(NEG8, NEG8, NEG8, NEG8, NEG8));
        check("alleq.relu_idx", 32'(idx_relu), 32'd0);

        // Second start two cycles into RUN must be ignored.
        vec_in = va; bias = '0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vec_in = vb; start = 1'b1;
        tick();
        start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_relu) dcnt++;
        end
        check("busystart.done_count", 32'(dcnt), 32'd1);
        check_vec("busystart.result", res_relu, va);
        check("busystart.idx", 32'(idx_relu), 32'd1);
        do_op("after_busy", vb, '0);
        check_vec("after_busy.result", res_relu, vb);
        check("after_busy.idx", 32'(idx_relu), 32'd3);

        // Abort mid-RUN with an asynchronous reset pulse.
        vec_in = vbasic; bias = bbasic; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        check_vec("abort.result", res_relu, '0);
        check("abort.idx", 32'(idx_relu), 32'd0);
        check("abort.busy", 32'(busy_relu), 32'd0);
        check("abort.done", 32'(done_relu), 32'd0);
        tick();
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_relu) dcnt++;
        end
        check("abort.no_done", 32'(dcnt), 32'd0);
        do_op("post_abort", vbasic, bbasic);
        check_vec("post_abort.result", res_relu, v5(32'h10000, 32'h0, 32'h8000, 32'h18000, 32'h0));
        check("post_abort.idx", 32'(idx_relu), 32'd3);

        saved = res_relu;
        saved_idx = idx_relu;
        dcnt = 0; chg = 0;
        for (int i = 0; i < 20; i++) begin
            for (int j = 0; j < N; j++) begin
                vec_in[j] = $urandom();
                bias[j]   = $urandom();
            end
            tick();
            if (done_relu) dcnt++;
            if (res_relu !== saved || idx_relu !== saved_idx) chg++;
        end
        check("hold.done_count", 32'(dcnt), 32'd0);
        check("hold.changes", 32'(chg), 32'd0);

        // start held high: back-to-back period is NUM_COL_MAT+2.
        vec_in = va; bias = '0; start = 1'b1;
        w = 0;
        do begin
            tick();
            w++;
        end while (!done_relu && w < 20);
        per = 0;
        do begin
            tick();
            per++;
        end while (!done_relu && per < 20);
        check("cont.period", 32'(per), 32'd7);
        start = 1'b0;
        tick();
        tick();
        check_vec("cont.result", res_relu, va);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
